// File: rtl/alu_addsub_seq.sv
// Multi-cycle XM23 add/subtract unit: carry chain walked CHUNK bits per clock,
// producing result plus V/N/Z/C flags behind valid/ready handshakes.
module alu_addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             byte_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_wr,
  output logic [15:0]      psw_out,
  output logic [15:0]      psw_msk
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int NCH_B = 8 / CHUNK;
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CW-1:0]    LAST_W    = CW'(NCH - 1);
  localparam logic [CW-1:0]    LAST_B    = CW'(NCH_B - 1);
  localparam logic [WIDTH-1:0] BYTE_MASK = WIDTH'(255);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDC = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SUBC = 3'd3;
  localparam logic [2:0] OP_CMP  = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, bx_q, sum_q, sum_now;
  logic [2:0]       op_q;
  logic             byte_q, carry_q;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   slice;
  logic             last_chunk, accept, sub_in, cin_sel;

  // V/N/Z/C taken at the active-width MSB; C is the final chain carry.
  function automatic logic [15:0] calc_psw(input logic [WIDTH-1:0] s,
                                           input logic [WIDTH-1:0] av,
                                           input logic [WIDTH-1:0] bv,
                                           input logic             bm,
                                           input logic             c);
    logic n, z, v, sa, sb;
    if (bm) begin
      n  = s[7];
      sa = av[7];
      sb = bv[7];
      z  = (s[7:0] == 8'h00);
    end else begin
      n  = s[WIDTH-1];
      sa = av[WIDTH-1];
      sb = bv[WIDTH-1];
      z  = (s == '0);
    end
    v = (sa == sb) && (n != sa);
    return {11'b0, v, 1'b0, n, z, c};
  endfunction

  // Byte mode keeps the destination's upper bits; CMP and reserved ops echo A.
  function automatic logic [WIDTH-1:0] merge_result(input logic [WIDTH-1:0] s,
                                                    input logic [WIDTH-1:0] av,
                                                    input logic             bm,
                                                    input logic [2:0]       o);
    logic [WIDTH-1:0] m;
    m = bm ? BYTE_MASK : '1;
    if (o <= OP_SUBC) return (s & m) | (av & ~m);
    return av;
  endfunction

  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign sub_in     = (op == OP_SUB) || (op == OP_SUBC) || (op == OP_CMP);
  assign last_chunk = byte_q ? (cnt_q == LAST_B) : (cnt_q == LAST_W);

  always_comb begin
    cin_sel = 1'b0;
    case (op)
      OP_ADDC, OP_SUBC: cin_sel = carry_in;
      OP_SUB,  OP_CMP:  cin_sel = 1'b1;
      default:          cin_sel = 1'b0;
    endcase
  end

  // Current chunk select and one CHUNK-wide slice of the carry chain.
  always_comb begin
    a_sl    = '0;
    b_sl    = '0;
    sum_now = sum_q;
    for (int k = 0; k < NCH; k++) begin
      if (cnt_q == CW'(k)) begin
        a_sl = a_q[k*CHUNK +: CHUNK];
        b_sl = bx_q[k*CHUNK +: CHUNK];
      end
    end
    slice = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    for (int k = 0; k < NCH; k++) begin
      if (cnt_q == CW'(k)) sum_now[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)     state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Operand latch and running sum; no reset needed, always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= a;
      bx_q    <= sub_in ? ~b : b;
      op_q    <= op;
      byte_q  <= byte_mode;
      carry_q <= cin_sel;
    end else if (state_q == RUN) begin
      carry_q <= slice[CHUNK];
      sum_q   <= sum_now;
    end
  end

  // Counter and registered outputs; reset discards any partial operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      res_wr    <= 1'b0;
      psw_out   <= '0;
      psw_msk   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) cnt_q <= '0;
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (last_chunk) begin
            cnt_q     <= '0;
            out_valid <= 1'b1;
            result    <= merge_result(sum_now, a_q, byte_q, op_q);
            res_wr    <= (op_q <= OP_SUBC);
            psw_out   <= (op_q <= OP_CMP)
                         ? calc_psw(sum_now, a_q, bx_q, byte_q, slice[CHUNK]) : 16'h0000;
            psw_msk   <= (op_q <= OP_CMP) ? 16'h0017 : 16'h0000;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Directed bench for alu_addsub_seq: literal expectations per operation plus a
// whole-word arithmetic model checked every cycle out_valid is high.
module tb_alu_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  op;
  logic        byte_mode;
  logic [15:0] a, b;
  logic        carry_in;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        res_wr;
  logic [15:0] psw_out, psw_msk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] r;
    logic        w;
    logic [15:0] p;
    logic [15:0] m;
  } exp_t;

  exp_t exp_cur;
  logic exp_ok = 1'b0;

  alu_addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .byte_mode(byte_mode), .a(a), .b(b), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .res_wr(res_wr), .psw_out(psw_out), .psw_msk(psw_msk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Whole-width arithmetic reference: a + b' + cin over the active width.
  function automatic exp_t model(input logic [2:0] o, input logic bm,
                                 input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci);
    int aw, mask, bb, c, s, sr, cy, sn, sa, sb, v, z;
    exp_t e;
    aw   = bm ? 8 : 16;
    mask = (1 << aw) - 1;
    case (o)
      3'd0:       begin bb = int'(bv);         c = 0;       end
      3'd1:       begin bb = int'(bv);         c = int'(ci); end
      3'd2, 3'd4: begin bb = int'(~bv);        c = 1;       end
      3'd3:       begin bb = int'(~bv);        c = int'(ci); end
      default:    begin bb = int'(bv);         c = 0;       end
    endcase
    s  = (int'(av) & mask) + (bb & mask) + c;
    cy = (s >> aw) & 1;
    sr = s & mask;
    sn = (sr >> (aw - 1)) & 1;
    sa = (int'(av) >> (aw - 1)) & 1;
    sb = (bb >> (aw - 1)) & 1;
    v  = ((sa == sb) && (sn != sa)) ? 1 : 0;
    z  = (sr == 0) ? 1 : 0;
    e.r = (o <= 3'd3) ? 16'((int'(av) & ~mask) | sr) : av;
    e.w = (o <= 3'd3);
    e.p = (o <= 3'd4) ? 16'(v * 16 + sn * 4 + z * 2 + cy) : 16'h0000;
    e.m = (o <= 3'd4) ? 16'h0017 : 16'h0000;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) exp_ok <= 1'b0;
    else if (in_valid && in_ready) begin
      exp_cur <= model(op, byte_mode, a, b, carry_in);
      exp_ok  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_ok) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        chk("mdl_result", result, exp_cur.r);
        chk("mdl_res_wr", res_wr, exp_cur.w);
        chk("mdl_psw",    psw_out, exp_cur.p);
        chk("mdl_msk",    psw_msk, exp_cur.m);
      end
    end
  end

  task automatic do_op(input string nm, input logic [2:0] o, input logic bm,
                       input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       input int exp_lat, input logic [15:0] er, input logic ew,
                       input logic [15:0] ep, input logic [15:0] em,
                       input int hold, input logic [2:0] ho,
                       input logic [15:0] ha, input logic [15:0] hb);
    int n, lat;
    @(negedge clk);
    in_valid = 1'b1; op = o; byte_mode = bm; a = av; b = bv; carry_in = ci;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~av; b = ~bv; carry_in = ~ci; byte_mode = ~bm;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_result"},  result,  er);
    chk({nm, "_res_wr"},  res_wr,  ew);
    chk({nm, "_psw"},     psw_out, ep);
    chk({nm, "_msk"},     psw_msk, em);
    if (hold > 0) begin
      in_valid = 1'b1; op = ho; a = ha; b = hb; byte_mode = 1'b0; carry_in = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({nm, "_hold_in_ready"},  in_ready,  1'b0);
        chk({nm, "_hold_out_valid"}, out_valid, 1'b1);
        chk({nm, "_hold_result"},    result,    er);
        chk({nm, "_hold_psw"},       psw_out,   ep);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_release_valid"}, out_valid, 1'b0);
    chk({nm, "_release_ready"}, in_ready,  1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; byte_mode = 1'b0;
    a = 16'h0; b = 16'h0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result",    result,    16'h0000);
    chk("rst_psw",       psw_out,   16'h0000);
    chk("rst_msk",       psw_msk,   16'h0000);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // ADD overflow with 3 cycles of backpressure while a SUB is offered
    do_op("add_ovf", 3'd0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 4,
          16'h8000, 1'b1, 16'h0014, 16'h0017, 3, 3'd2, 16'h0005, 16'h0005);
    do_op("sub_eq",  3'd2, 1'b0, 16'h0005, 16'h0005, 1'b0, 4,
          16'h0000, 1'b1, 16'h0003, 16'h0017, 0, 3'd0, 16'h0, 16'h0);
    do_op("subc",    3'd3, 1'b0, 16'h0000, 16'h0001, 1'b1, 4,
          16'hFFFF, 1'b1, 16'h0004, 16'h0017, 0, 3'd0, 16'h0, 16'h0);
    do_op("addc",    3'd1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 4,
          16'h0000, 1'b1, 16'h0003, 16'h0017, 0, 3'd0, 16'h0, 16'h0);
    do_op("byte_add", 3'd0, 1'b1, 16'h12FF, 16'h0001, 1'b0, 2,
          16'h1200, 1'b1, 16'h0003, 16'h0017, 0, 3'd0, 16'h0, 16'h0);
    do_op("byte_sub", 3'd2, 1'b1, 16'hAB10, 16'h0020, 1'b0, 2,
          16'hABF0, 1'b1, 16'h0004, 16'h0017, 0, 3'd0, 16'h0, 16'h0);
    do_op("cmp",     3'd4, 1'b0, 16'h0003, 16'h0004, 1'b0, 4,
          16'h0003, 1'b0, 16'h0004, 16'h0017, 0, 3'd0, 16'h0, 16'h0);

    // Reset after two of four chunks
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; byte_mode = 1'b0; a = 16'h1234; b = 16'h1111; carry_in = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_result",    result,    16'h0000);
    chk("mid_rst_res_wr",    res_wr,    1'b0);
    chk("mid_rst_psw",       psw_out,   16'h0000);
    chk("mid_rst_msk",       psw_msk,   16'h0000);
    chk("mid_rst_in_ready",  in_ready,  1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("mid_rel_out_valid", out_valid, 1'b0);

    do_op("add_post_rst", 3'd0, 1'b0, 16'h0001, 16'h0001, 1'b0, 4,
          16'h0002, 1'b1, 16'h0000, 16'h0017, 0, 3'd0, 16'h0, 16'h0);
    do_op("reserved7", 3'd7, 1'b0, 16'hBEEF, 16'h1234, 1'b1, 4,
          16'hBEEF, 1'b0, 16'h0000, 16'h0000, 0, 3'd0, 16'h0, 16'h0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
